conf_int_mul_pipe: RTL and testbench



---
 rtl/conf_int_mul_pkg.sv | 19 +
 rtl/conf_int_mul_pipe_if.sv | 28 ++
 rtl/conf_int_mul_opnd_cond.sv | 43 ++++
 rtl/conf_int_mul_pipe.sv | 123 ++++++++++++
 tb/tb_conf_int_mul_pipe.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conf_int_mul_pkg.sv
// Shared constants and elaboration helpers for the configurable-precision
// integer multiplier.
package conf_int_mul_pkg;

    localparam int BT_RND_TRUNC = 0;
    localparam int BT_RND_ROUND = 1;

    // Number of low operand bits discarded by the precision reduction.
    function automatic int trunc_bits(int dp_bits, int op_bits);
        return dp_bits - op_bits;
    endfunction

    function automatic bit params_ok(int dp_bits, int op_bits, int pipe_stages, int bt_rnd);
        return (dp_bits >= 1) && (op_bits >= 1) && (op_bits <= dp_bits) &&
               (pipe_stages >= 1) && (pipe_stages <= 4) &&
               ((bt_rnd == BT_RND_TRUNC) || (bt_rnd == BT_RND_ROUND));
    endfunction

endpackage

// File: rtl/conf_int_mul_pipe_if.sv
// Operand/result handshake bundle for conf_int_mul_pipe.
interface conf_int_mul_pipe_if #(
    parameter int DATA_PATH_BITWIDTH = 16
);
    // Handshake: a transfer happens on a rising edge where valid && ready.
    // A producer holds valid and its data until that edge; ready may depend on
    // the consumer's ready combinationally, never on the producer's valid.
    logic                              in_valid;
    logic                              in_ready;
    logic [DATA_PATH_BITWIDTH-1:0]     a;
    logic [DATA_PATH_BITWIDTH-1:0]     b;
    logic                              sgn;
    logic                              out_valid;
    logic                              out_ready;
    logic [2*DATA_PATH_BITWIDTH-1:0]   d;
    logic [2:0]                        occ;

    modport master (
        output in_valid, a, b, sgn, out_ready,
        input  in_ready, out_valid, d, occ
    );

    modport slave (
        input  in_valid, a, b, sgn, out_ready,
        output in_ready, out_valid, d, occ
    );

endinterface

// File: rtl/conf_int_mul_opnd_cond.sv
// Combinational operand reducer: keeps the top OP_BITWIDTH bits by truncation
// or by round-to-nearest with saturation.
module conf_int_mul_opnd_cond
    import conf_int_mul_pkg::*;
#(
    parameter int DATA_PATH_BITWIDTH = 16,
    parameter int OP_BITWIDTH        = 16,
    parameter int BT_RND             = BT_RND_TRUNC
) (
    input  logic [DATA_PATH_BITWIDTH-1:0] x,
    input  logic                          sgn,
    output logic [DATA_PATH_BITWIDTH-1:0] x_red
);
    localparam int DW = DATA_PATH_BITWIDTH;
    localparam int T  = trunc_bits(DATA_PATH_BITWIDTH, OP_BITWIDTH);
    localparam logic [DW-1:0] KEEP_MASK = {DW{1'b1}} << T;

    logic w_unused_sgn;
    assign w_unused_sgn = sgn;

    if (T == 0) begin : g_identity
        assign x_red = x;
    end else if (BT_RND == BT_RND_TRUNC) begin : g_trunc
        assign x_red = x & KEEP_MASK;
    end else begin : g_round
        localparam logic [DW:0] HALF = (DW+1)'(1) << (T - 1);
        logic [DW:0] w_sum;

        assign w_sum = {1'b0, x} + HALF;

        // Unsigned overflow shows as carry-out; signed overflow only when a
        // non-negative operand wraps to negative, so negatives never saturate.
        always_comb begin
            x_red = w_sum[DW-1:0] & KEEP_MASK;
            if (!sgn && w_sum[DW]) begin
                x_red = KEEP_MASK;
            end else if (sgn && !x[DW-1] && w_sum[DW-1]) begin
                x_red = {1'b0, {(DW-1){1'b1}}} & KEEP_MASK;
            end
        end
    end

endmodule

// File: rtl/conf_int_mul_pipe.sv
// Pipelined signed/unsigned multiplier with reduced-precision operands and
// a back-pressurable valid/ready stage chain.
module conf_int_mul_pipe
    import conf_int_mul_pkg::*;
#(
    parameter int OP_BITWIDTH        = 16,
    parameter int DATA_PATH_BITWIDTH = 16,
    parameter int PIPE_STAGES        = 2,
    parameter int BT_RND             = BT_RND_TRUNC
) (
    input  logic               clk,
    input  logic               rst,
    conf_int_mul_pipe_if.slave mul_if
);
    localparam int DW = DATA_PATH_BITWIDTH;
    localparam int PW = 2 * DATA_PATH_BITWIDTH;

    if (!params_ok(DATA_PATH_BITWIDTH, OP_BITWIDTH, PIPE_STAGES, BT_RND)) begin : g_param_err
        $error("conf_int_mul_pipe: parameter out of range");
    end

    logic [DW-1:0]          w_a_red;
    logic [DW-1:0]          w_b_red;
    logic [PIPE_STAGES-1:0] r_vld;
    logic [PIPE_STAGES-1:0] w_load;
    logic [DW-1:0]          r_a0;
    logic [DW-1:0]          r_b0;
    logic                   r_sgn0;
    logic [PW-1:0]          w_ax;
    logic [PW-1:0]          w_bx;
    logic [PW-1:0]          w_prod;
    logic [2:0]             w_occ;

    conf_int_mul_opnd_cond #(
        .DATA_PATH_BITWIDTH(DATA_PATH_BITWIDTH),
        .OP_BITWIDTH       (OP_BITWIDTH),
        .BT_RND            (BT_RND)
    ) u_cond_a (
        .x    (mul_if.a),
        .sgn  (mul_if.sgn),
        .x_red(w_a_red)
    );

    conf_int_mul_opnd_cond #(
        .DATA_PATH_BITWIDTH(DATA_PATH_BITWIDTH),
        .OP_BITWIDTH       (OP_BITWIDTH),
        .BT_RND            (BT_RND)
    ) u_cond_b (
        .x    (mul_if.b),
        .sgn  (mul_if.sgn),
        .x_red(w_b_red)
    );

    // Stage k may load when it is empty or its content moves on this edge.
    always_comb begin : load_chain
        logic go;
        w_load = '0;
        go = !r_vld[PIPE_STAGES-1] || mul_if.out_ready;
        w_load[PIPE_STAGES-1] = go;
        for (int k = PIPE_STAGES - 2; k >= 0; k--) begin
            go = !r_vld[k] || go;
            w_load[k] = go;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld <= '0;
        end else begin
            if (w_load[0]) r_vld[0] <= mul_if.in_valid;
            for (int k = 1; k < PIPE_STAGES; k++) begin
                if (w_load[k]) r_vld[k] <= r_vld[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a0   <= '0;
            r_b0   <= '0;
            r_sgn0 <= 1'b0;
        end else if (w_load[0]) begin
            r_a0   <= w_a_red;
            r_b0   <= w_b_red;
            r_sgn0 <= mul_if.sgn;
        end
    end

    // Sign- or zero-extending to the product width lets one unsigned
    // multiplier serve both modes; the low PW bits are exact in either case.
    assign w_ax   = r_sgn0 ? {{DW{r_a0[DW-1]}}, r_a0} : {{DW{1'b0}}, r_a0};
    assign w_bx   = r_sgn0 ? {{DW{r_b0[DW-1]}}, r_b0} : {{DW{1'b0}}, r_b0};
    assign w_prod = w_ax * w_bx;

    if (PIPE_STAGES > 1) begin : g_prod_stages
        logic [PW-1:0] r_prod [PIPE_STAGES-1];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int k = 0; k < PIPE_STAGES - 1; k++) r_prod[k] <= '0;
            end else begin
                if (w_load[1]) r_prod[0] <= w_prod;
                for (int k = 2; k < PIPE_STAGES; k++) begin
                    if (w_load[k]) r_prod[k-1] <= r_prod[k-2];
                end
            end
        end

        assign mul_if.d = r_prod[PIPE_STAGES-2];
    end else begin : g_prod_comb
        assign mul_if.d = w_prod;
    end

    always_comb begin
        w_occ = '0;
        for (int k = 0; k < PIPE_STAGES; k++) w_occ = w_occ + 3'(r_vld[k]);
    end

    assign mul_if.in_ready  = w_load[0];
    assign mul_if.out_valid = r_vld[PIPE_STAGES-1];
    assign mul_if.occ       = w_occ;

endmodule

// File: tb/tb_conf_int_mul_pipe.sv
// Bench for conf_int_mul_pipe: three configurations side by side, directed
// corner cases plus random streams checked by a queue-based scoreboard.
module tb_conf_int_mul_pipe;

    localparam int NI = 3;
    localparam int OPS  [NI] = '{16, 8, 8};
    localparam int PIPS [NI] = '{2, 3, 1};
    localparam int RNDS [NI] = '{0, 1, 0};

    logic clk;
    logic rst_n;

    logic        tb_in_valid  [NI];
    logic        tb_in_ready  [NI];
    logic [15:0] tb_a         [NI];
    logic [15:0] tb_b         [NI];
    logic        tb_sgn       [NI];
    logic        tb_out_valid [NI];
    logic        tb_out_ready [NI];
    logic [31:0] tb_d         [NI];
    logic [2:0]  tb_occ       [NI];

    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    logic [31:0] exp_q2[$];

    int n_checks = 0;
    int n_fail   = 0;
    bit sim_done = 0;
    bit rnd_done = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        conf_int_mul_pipe_if #(.DATA_PATH_BITWIDTH(16)) mul_if ();

        assign mul_if.in_valid  = tb_in_valid[g];
        assign mul_if.a         = tb_a[g];
        assign mul_if.b         = tb_b[g];
        assign mul_if.sgn       = tb_sgn[g];
        assign mul_if.out_ready = tb_out_ready[g];
        assign tb_in_ready[g]   = mul_if.in_ready;
        assign tb_out_valid[g]  = mul_if.out_valid;
        assign tb_d[g]          = mul_if.d;
        assign tb_occ[g]        = mul_if.occ;

        conf_int_mul_pipe #(
            .OP_BITWIDTH       (OPS[g]),
            .DATA_PATH_BITWIDTH(16),
            .PIPE_STAGES       (PIPS[g]),
            .BT_RND            (RNDS[g])
        ) u_dut (
            .clk   (clk),
            .rst   (rst_n),
            .mul_if(mul_if)
        );
    end

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [15:0] ref_reduce(logic [15:0] x, logic s, int op, int rnd);
        int t  = 16 - op;
        int ux = int'(x);
        int sx = int'($signed(x));
        int v;
        if (t == 0) return x;
        if (rnd == 0) return 16'((ux >> t) << t);
        v = (s ? sx : ux) + (1 << (t - 1));
        if (!s && v > 65535) return 16'((65535 >> t) << t);
        if (s && v > 32767)  return 16'((32767 >> t) << t);
        return 16'((v >>> t) <<< t);
    endfunction

    function automatic logic [31:0] ref_prod(int k, logic [15:0] av, logic [15:0] bv, logic s);
        logic [15:0] ra = ref_reduce(av, s, OPS[k], RNDS[k]);
        logic [15:0] rb = ref_reduce(bv, s, OPS[k], RNDS[k]);
        longint pa = s ? longint'($signed(ra)) : longint'(ra);
        longint pb = s ? longint'($signed(rb)) : longint'(rb);
        longint p  = pa * pb;
        return p[31:0];
    endfunction

    // ---------------- scoreboard helpers ----------------
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic push_exp(int k, logic [31:0] v);
        case (k)
            0:       exp_q0.push_back(v);
            1:       exp_q1.push_back(v);
            default: exp_q2.push_back(v);
        endcase
    endtask

    function automatic int qsize(int k);
        case (k)
            0:       return exp_q0.size();
            1:       return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    task automatic pop_exp(int k, output logic [31:0] v, output bit ok);
        ok = (qsize(k) != 0);
        v  = '0;
        if (ok) begin
            case (k)
                0:       v = exp_q0.pop_front();
                1:       v = exp_q1.pop_front();
                default: v = exp_q2.pop_front();
            endcase
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send(int k, logic [15:0] av, logic [15:0] bv, logic s);
        tb_a[k] = av;
        tb_b[k] = bv;
        tb_sgn[k] = s;
        tb_in_valid[k] = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tb_in_ready[k]) begin
                push_exp(k, ref_prod(k, av, bv, s));
                @(posedge clk);
                #1;
                tb_in_valid[k] = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        fail_now($sformatf("send_timeout_%0d", k));
        tb_in_valid[k] = 1'b0;
    endtask

    task automatic expect_out(int k, string name, logic [31:0] exp);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tb_out_valid[k]) begin
                chk(name, tb_d[k], exp);
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        fail_now(name);
    endtask

    task automatic drain(int k);
        tb_out_ready[k] = 1'b1;
        for (int i = 0; i < 60 && qsize(k) != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk($sformatf("drain_empty_%0d", k), qsize(k), 0);
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            4:       return 16'h7FF0;
            default: return 16'($urandom);
        endcase
    endfunction

    // ---------------- stimulus + monitor ----------------
    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < NI; k++) begin
            tb_in_valid[k]  = 1'b0;
            tb_a[k]         = '0;
            tb_b[k]         = '0;
            tb_sgn[k]       = 1'b0;
            tb_out_ready[k] = 1'b1;
        end

        fork
            begin : main_seq
                repeat (3) @(posedge clk);
                #1;
                for (int k = 0; k < NI; k++) begin
                    chk($sformatf("rst_out_valid_%0d", k), tb_out_valid[k], 0);
                    chk($sformatf("rst_occ_%0d", k), tb_occ[k], 0);
                    chk($sformatf("rst_d_%0d", k), tb_d[k], 0);
                end
                rst_n = 1'b1;
                @(posedge clk);
                #1;
                for (int k = 0; k < NI; k++) chk($sformatf("rst_in_ready_%0d", k), tb_in_ready[k], 1);

                // Latency and basic products, PIPE_STAGES = 2.
                send(0, 16'd3, 16'd5, 1'b0);
                chk("lat2_not_yet", tb_out_valid[0], 0);
                chk("lat2_occ1", tb_occ[0], 1);
                @(posedge clk);
                #1;
                chk("lat2_valid", tb_out_valid[0], 1);
                chk("lat2_d", tb_d[0], 32'd15);
                @(posedge clk);
                #1;
                send(0, 16'hFFFE, 16'h0003, 1'b1);
                expect_out(0, "signed_neg", 32'hFFFFFFFA);
                send(0, 16'hFFFE, 16'h0003, 1'b0);
                expect_out(0, "unsigned_big", 32'h0002FFFA);

                // Truncation, PIPE_STAGES = 1 (result visible right after accept).
                send(2, 16'h01FF, 16'h0100, 1'b0);
                chk("lat1_valid", tb_out_valid[2], 1);
                chk("trunc_unsigned", tb_d[2], 32'h00010000);
                @(posedge clk);
                #1;
                send(2, 16'h81FF, 16'h0300, 1'b1);
                expect_out(2, "trunc_signed", 32'hFE830000);

                // Rounding and saturation, PIPE_STAGES = 3.
                send(1, 16'h01FF, 16'h0100, 1'b0);
                expect_out(1, "round_up", 32'h00020000);
                send(1, 16'hFFF0, 16'h0100, 1'b0);
                expect_out(1, "round_sat_u", 32'h00FF0000);
                send(1, 16'h7FF0, 16'h0100, 1'b1);
                expect_out(1, "round_sat_s", 32'h007F0000);
                send(1, 16'hFF7F, 16'h0100, 1'b1);
                expect_out(1, "round_neg", 32'hFFFF0000);

                // Back-pressure on the 3-stage pipe with a 10-op stream.
                tb_out_ready[1] = 1'b0;
                fork
                    begin
                        for (int i = 0; i < 10; i++) send(1, pick(), pick(), 1'($urandom_range(0, 1)));
                    end
                    begin
                        logic [31:0] held;
                        int n;
                        n = 0;
                        while (tb_occ[1] != 3'd3 && n < 50) begin
                            @(posedge clk);
                            #1;
                            n++;
                        end
                        chk("stall_occ_full", tb_occ[1], 3);
                        chk("stall_in_ready", tb_in_ready[1], 0);
                        held = tb_d[1];
                        repeat (4) begin
                            @(posedge clk);
                            #1;
                            chk("stall_d_held", tb_d[1], held);
                            chk("stall_valid_held", tb_out_valid[1], 1);
                            chk("stall_in_ready_low", tb_in_ready[1], 0);
                        end
                        tb_out_ready[1] = 1'b1;
                        @(posedge clk);
                        #1;
                        chk("full_accept_emit_occ", tb_occ[1], 3);
                    end
                join
                drain(1);

                // Random streams with random back-pressure on every config.
                for (int k = 0; k < NI; k++) begin
                    rnd_done = 1'b0;
                    fork
                        begin
                            for (int i = 0; i < 60; i++) begin
                                repeat ($urandom_range(0, 2)) begin
                                    @(posedge clk);
                                    #1;
                                end
                                send(k, pick(), pick(), 1'($urandom_range(0, 1)));
                            end
                            rnd_done = 1'b1;
                        end
                        begin
                            while (!rnd_done) begin
                                @(posedge clk);
                                #1;
                                tb_out_ready[k] = ($urandom_range(0, 3) != 0);
                            end
                        end
                    join
                    drain(k);
                end

                // Reset with two transactions in flight.
                tb_out_ready[0] = 1'b0;
                send(0, 16'h1234, 16'h0042, 1'b0);
                send(0, 16'h8001, 16'h0007, 1'b1);
                chk("pre_reset_occ", tb_occ[0], 2);
                @(posedge clk);
                #2;
                rst_n = 1'b0;
                #1;
                chk("mid_reset_out_valid", tb_out_valid[0], 0);
                chk("mid_reset_occ", tb_occ[0], 0);
                exp_q0.delete();
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                tb_out_ready[0] = 1'b1;
                @(posedge clk);
                #1;
                send(0, 16'd7, 16'd9, 1'b0);
                expect_out(0, "post_reset_prod", 32'd63);
                @(posedge clk);
                #1;
                for (int k = 0; k < NI; k++) chk($sformatf("final_empty_%0d", k), qsize(k), 0);
                sim_done = 1'b1;
            end

            begin : monitor
                logic [31:0] held_d [NI];
                bit          held   [NI];
                logic [31:0] e;
                bit          ok;
                for (int k = 0; k < NI; k++) begin
                    held[k]   = 1'b0;
                    held_d[k] = '0;
                end
                while (!sim_done) begin
                    @(negedge clk);
                    for (int k = 0; k < NI; k++) begin
                        if (held[k] && rst_n) begin
                            chk($sformatf("hold_valid_%0d", k), tb_out_valid[k], 1);
                            chk($sformatf("hold_d_%0d", k), tb_d[k], held_d[k]);
                        end
                        if (rst_n && tb_out_valid[k] && tb_out_ready[k]) begin
                            pop_exp(k, e, ok);
                            if (!ok) fail_now($sformatf("sb_unexpected_output_%0d", k));
                            else chk($sformatf("sb_d_%0d", k), tb_d[k], e);
                        end
                        held[k]   = rst_n && tb_out_valid[k] && !tb_out_ready[k];
                        held_d[k] = tb_d[k];
                    end
                end
            end
        join

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
